// File: rtl/adc_iq_sequencer.sv
// I/Q ADC conversion sequencer: alternates the mux between I and Q, starts conversions, forwards samples.
// Optional conversion watchdog enabled by defining ADC_SEQ_WATCHDOG_EN.
module adc_iq_sequencer #(
    parameter logic [2:0] I_CH        = 3'b110,
    parameter logic [2:0] Q_CH        = 3'b100,
    parameter int         SETTLE_CYC  = 4,
    parameter int         TIMEOUT_CYC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [2:0] adc_ch,
    output logic       adc_soc,
    input  logic       adc_eoc,
    input  logic [9:0] adc_data,
    output logic       smp_en,
    output logic [2:0] smp_channel,
    output logic [9:0] smp_data,
    output logic       pair_done,
    output logic       overrun,
    output logic       timeout,
    input  logic       clr_flags
);

    // state  | meaning
    // IDLE   | mux parked on I, waiting for run
    // SETTLE | mux held for SETTLE_CYC clocks
    // START  | one-clock start-of-conversion
    // WAIT   | waiting for end-of-conversion (watchdog optional)
    // EMIT   | one-clock sample strobe, then advance the channel
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        EMIT   = 3'd4
    } state_t;

`ifdef ADC_SEQ_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        on_q;
    logic [7:0]  settle_cnt;
    logic [15:0] wdog_cnt;
    logic        capture;
    logic        wdog_expire;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        adc_soc     = 1'b0;
        smp_en      = 1'b0;
        pair_done   = 1'b0;
        capture     = 1'b0;
        wdog_expire = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 8'd0) state_nxt = START;
            end
            START: begin
                adc_soc   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A late eoc on the terminal-count clock is still accepted.
                if (adc_eoc) begin
                    capture   = 1'b1;
                    state_nxt = EMIT;
                end else if (WDOG_EN && (wdog_cnt == 16'd1)) begin
                    wdog_expire = 1'b1;
                    state_nxt   = run ? SETTLE : IDLE;
                end
            end
            EMIT: begin
                smp_en    = 1'b1;
                pair_done = on_q;
                state_nxt = run ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            on_q        <= 1'b0;
            adc_ch      <= I_CH;
            settle_cnt  <= 8'd0;
            wdog_cnt    <= 16'd0;
            smp_channel <= 3'd0;
            smp_data    <= 10'd0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if ((state_nxt == SETTLE) && (state != SETTLE))
                settle_cnt <= 8'(SETTLE_CYC - 1);
            else if ((state == SETTLE) && (settle_cnt != 8'd0))
                settle_cnt <= settle_cnt - 8'd1;

            if (state == START)
                wdog_cnt <= 16'(TIMEOUT_CYC);
            else if ((state == WAIT) && (wdog_cnt != 16'd0))
                wdog_cnt <= wdog_cnt - 16'd1;

            if (capture) begin
                smp_data    <= adc_data;
                smp_channel <= adc_ch;
            end

            // Only an I emit with run still high moves on to Q; everything else re-arms on I.
            if ((state == EMIT) && run && !on_q) begin
                on_q   <= 1'b1;
                adc_ch <= Q_CH;
            end else if ((state == EMIT) || wdog_expire) begin
                on_q   <= 1'b0;
                adc_ch <= I_CH;
            end

            if (adc_eoc && (state != WAIT)) overrun <= 1'b1;
            else if (clr_flags)             overrun <= 1'b0;

            if (wdog_expire)    timeout <= 1'b1;
            else if (clr_flags) timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_iq_sequencer.sv
// Directed-vector bench for adc_iq_sequencer (default mux codes and settle time, TIMEOUT_CYC=16).
module tb_adc_iq_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       adc_eoc;
    logic [9:0] adc_data;
    logic       clr_flags;
    logic [2:0] adc_ch;
    logic       adc_soc;
    logic       smp_en;
    logic [2:0] smp_channel;
    logic [9:0] smp_data;
    logic       pair_done;
    logic       overrun;
    logic       timeout;

    int applied     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adc_iq_sequencer #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .adc_ch     (adc_ch),
        .adc_soc    (adc_soc),
        .adc_eoc    (adc_eoc),
        .adc_data   (adc_data),
        .smp_en     (smp_en),
        .smp_channel(smp_channel),
        .smp_data   (smp_data),
        .pair_done  (pair_done),
        .overrun    (overrun),
        .timeout    (timeout),
        .clr_flags  (clr_flags)
    );

    typedef struct {
        logic       rst;
        logic       run;
        logic       eoc;
        logic [9:0] data;
        logic       clr;
        logic [2:0] ch;
        logic       soc;
        logic       en;
        logic [2:0] sch;
        logic [9:0] sd;
        logic       pd;
        logic       ov;
    } vec_t;

    vec_t tbl[27];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {11'd0, adc_ch, adc_soc, smp_en, smp_channel, smp_data, pair_done, overrun, timeout};
    endfunction

    task automatic wait_soc(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!adc_soc && n < 40);
        chk(name, n, exp_n);
    endtask

    // Entered in the soc clock; presents eoc 'gap' clocks later and checks the strobe one clock after.
    task automatic convert(input string name, input int gap, input logic [9:0] d,
                           input logic [2:0] exp_ch, input logic exp_pd);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < gap; i++) begin
            step();
            seen = seen | smp_en | pair_done;
        end
        chk({name, " quiet"}, seen, 0);
        adc_eoc  = 1'b1;
        adc_data = d;
        step();
        adc_eoc  = 1'b0;
        adc_data = 10'd0;
        chk({name, " en"},   smp_en, 1);
        chk({name, " ch"},   smp_channel, exp_ch);
        chk({name, " data"}, smp_data, d);
        chk({name, " pd"},   pair_done, exp_pd);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int socs;
        logic seen;

        tbl[0]  = '{1'b1,1'b0,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b1,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd0,10'h000,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b1,10'h3FF,1'b0, 3'd6,1'b0,1'b1,3'd6,10'h3FF,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b1,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd4,1'b0,1'b0,3'd6,10'h3FF,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b1,10'h000,1'b0, 3'd4,1'b0,1'b1,3'd4,10'h000,1'b1,1'b0};
        tbl[16] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd4,10'h000,1'b0,1'b0};
        tbl[17] = '{1'b0,1'b1,1'b1,10'h155,1'b0, 3'd6,1'b0,1'b0,3'd4,10'h000,1'b0,1'b1};
        tbl[18] = '{1'b0,1'b1,1'b0,10'h000,1'b1, 3'd6,1'b0,1'b0,3'd4,10'h000,1'b0,1'b0};
        tbl[19] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd4,10'h000,1'b0,1'b0};
        tbl[20] = '{1'b0,1'b1,1'b0,10'h000,1'b0, 3'd6,1'b1,1'b0,3'd4,10'h000,1'b0,1'b0};
        tbl[21] = '{1'b0,1'b0,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd4,10'h000,1'b0,1'b0};
        tbl[22] = '{1'b0,1'b0,1'b1,10'h2A5,1'b0, 3'd6,1'b0,1'b1,3'd6,10'h2A5,1'b0,1'b0};
        tbl[23] = '{1'b0,1'b0,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd6,10'h2A5,1'b0,1'b0};
        tbl[24] = '{1'b0,1'b0,1'b1,10'h000,1'b1, 3'd6,1'b0,1'b0,3'd6,10'h2A5,1'b0,1'b1};
        tbl[25] = '{1'b0,1'b0,1'b0,10'h000,1'b0, 3'd6,1'b0,1'b0,3'd6,10'h2A5,1'b0,1'b1};
        tbl[26] = '{1'b0,1'b0,1'b0,10'h000,1'b1, 3'd6,1'b0,1'b0,3'd6,10'h2A5,1'b0,1'b0};

        rst = 1'b1; run = 1'b0; adc_eoc = 1'b0; adc_data = 10'd0; clr_flags = 1'b0;

        for (int i = 0; i < 27; i++) begin
            rst       = tbl[i].rst;
            run       = tbl[i].run;
            adc_eoc   = tbl[i].eoc;
            adc_data  = tbl[i].data;
            clr_flags = tbl[i].clr;
            step();
            chk($sformatf("vec%0d", i), obs(),
                {11'd0, tbl[i].ch, tbl[i].soc, tbl[i].en, tbl[i].sch, tbl[i].sd,
                 tbl[i].pd, tbl[i].ov, 1'b0});
        end
        adc_eoc = 1'b0; clr_flags = 1'b0;

        // Two full pairs with eoc 10 clocks after each soc.
        rst = 1'b1; step(); rst = 1'b0; run = 1'b1;
        wait_soc("first soc", 5);
        convert("I0", 10, 10'h3FF, 3'd6, 1'b0);
        step();
        chk("mux to Q", adc_ch, 3'd4);
        chk("I0 strobe width", smp_en | pair_done, 0);
        wait_soc("settle Q0", 4);
        convert("Q0", 10, 10'h000, 3'd4, 1'b1);
        step();
        chk("mux to I", adc_ch, 3'd6);
        chk("Q0 strobe width", smp_en | pair_done, 0);
        wait_soc("settle I1", 4);
        convert("I1", 10, 10'h3FF, 3'd6, 1'b0);
        step();
        wait_soc("settle Q1", 4);
        convert("Q1", 10, 10'h000, 3'd4, 1'b1);
        step();
        chk("hold data", smp_data, 10'h000);

        // Withheld eoc on Q.
        wait_soc("settle I2", 4);
        convert("I2", 2, 10'h0AA, 3'd6, 1'b0);
        step();
        wait_soc("settle Q2", 4);
        seen = 1'b0;
`ifdef ADC_SEQ_WATCHDOG_EN
        for (int i = 0; i < 16; i++) begin
            step();
            seen = seen | smp_en;
        end
        chk("timeout early", timeout, 0);
        step();
        chk("timeout set", timeout, 1);
        chk("no Q emit", seen | smp_en, 0);
        chk("mux back to I", adc_ch, 3'd6);
        wait_soc("retry I", 4);
        convert("I after timeout", 1, 10'h123, 3'd6, 1'b0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("timeout cleared", timeout, 0);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | smp_en | timeout;
        end
        chk("wait forever", seen, 0);
        convert("Q late", 0, 10'h0F0, 3'd4, 1'b1);
        step();
        wait_soc("settle I3", 4);
        convert("I3", 1, 10'h123, 3'd6, 1'b0);
        step();
`endif

        // run dropped during the Q conversion.
        wait_soc("settle Q stop", 4);
        run = 1'b0;
        convert("Q stop", 3, 10'h1C3, 3'd4, 1'b1);
        step();
        chk("stop mux", adc_ch, 3'd6);
        socs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (adc_soc) socs++;
        end
        chk("stop no soc", socs, 0);
        chk("stop overrun", overrun, 0);

        // Reset in WAIT together with eoc.
        run = 1'b1;
        wait_soc("restart", 5);
        step();
        step();
        rst = 1'b1; adc_eoc = 1'b1; adc_data = 10'h3A5;
        step();
        rst = 1'b0; adc_eoc = 1'b0; adc_data = 10'd0; run = 1'b0;
        chk("reset in WAIT", obs(), {11'd0, 3'd6, 1'b0, 1'b0, 3'd0, 10'h000, 1'b0, 1'b0, 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | adc_soc | smp_en;
        end
        chk("idle after reset", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_iq_sequencer.md
ADC_IQ_SEQUENCER -- requirements
Module: adc_iq_sequencer

Interface
REQ-001 SHALL have parameter I_CH, default 3'b110, ADC mux code of the I input.
REQ-002 SHALL have parameter Q_CH, default 3'b100, ADC mux code of the Q input.
REQ-003 SHALL have parameter SETTLE_CYC, default 4, range 1..255; clocks between a mux change and adc_soc.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 200, range 1..65535; maximum clocks from adc_soc to adc_eoc.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port run, input, 1, enables sequencing.
REQ-008 SHALL have port adc_ch, output, 3, ADC mux select.
REQ-009 SHALL have port adc_soc, output, 1, one-clock start-of-conversion pulse.
REQ-010 SHALL have port adc_eoc, input, 1, one-clock end-of-conversion pulse.
REQ-011 SHALL have port adc_data, input, 10, offset-binary sample, valid while adc_eoc=1.
REQ-012 SHALL have port smp_en, output, 1, one-clock strobe to the demodulator datapath.
REQ-013 SHALL have port smp_channel, output, 3, channel code qualified by smp_en.
REQ-014 SHALL have port smp_data, output, 10, sample qualified by smp_en.
REQ-015 SHALL have port pair_done, output, 1, one-clock pulse when the Q sample of an I/Q pair is emitted.
REQ-016 SHALL have port overrun, output, 1, sticky flag: unexpected adc_eoc.
REQ-017 SHALL have port timeout, output, 1, sticky flag: conversion watchdog expired.
REQ-018 SHALL have port clr_flags, input, 1, clears overrun and timeout.

Function
REQ-019 SHALL implement the states IDLE, SETTLE, START, WAIT, EMIT.
REQ-020 IDLE: adc_ch=I_CH; the next-channel pointer SHALL be I; go to SETTLE when run=1.
REQ-021 SETTLE: count SETTLE_CYC clocks with adc_ch held, then go to START.
REQ-022 START: assert adc_soc for exactly one clock, load the watchdog, go to WAIT.
REQ-023 WAIT: on adc_eoc=1, register adc_data and the current channel code, then go to EMIT.
REQ-024 EMIT: assert smp_en for one clock with the registered smp_data and smp_channel.
REQ-025 EMIT on channel Q_CH SHALL also assert pair_done in the same clock.
REQ-026 Leaving EMIT SHALL toggle the channel pointer, update adc_ch, and go to SETTLE if run=1, else IDLE.
REQ-027 Latency from adc_eoc to smp_en SHALL be exactly 1 clock.
REQ-028 Emitted order SHALL always be I, Q, I, Q; a Q sample SHALL never be emitted without its preceding I.
REQ-029 run deasserted mid-pair SHALL let the current conversion complete and emit, then go to IDLE; the pair pointer SHALL reset to I.
REQ-030 adc_eoc in any state other than WAIT SHALL set overrun and SHALL be otherwise ignored, with no emit.
REQ-031 clr_flags and a set event in the same clock: the set SHALL win.
REQ-032 smp_data SHALL hold its last value between strobes; smp_en and pair_done SHALL be 0 outside EMIT.

Reset
REQ-033 With rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-034 Reset values SHALL be adc_ch=I_CH, adc_soc=0, smp_en=0, smp_channel=0, smp_data=0, pair_done=0, overrun=0, timeout=0.
REQ-035 The counters and the channel pointer SHALL be 0 / I after reset.
REQ-036 Reset SHALL take priority over run, adc_eoc and clr_flags, including in the middle of a conversion.

Configuration
REQ-037 SHALL honour the macro ADC_SEQ_WATCHDOG_EN.
REQ-038 With ADC_SEQ_WATCHDOG_EN defined, WAIT SHALL count down from TIMEOUT_CYC.
REQ-039 On watchdog expiry, the block SHALL set timeout, discard the partial pair without emitting, set the pointer to I, and go to SETTLE (or IDLE if run=0).
REQ-040 Without ADC_SEQ_WATCHDOG_EN, WAIT SHALL wait indefinitely and timeout SHALL be constant 0.

Verification
REQ-041 Reset then run=1 with eoc 10 clocks after each soc (I data 0x3FF, Q data 0x000): expect smp_en pulses I(6,0x3FF), Q(4,0x000), with pair_done on the Q pulse only.
REQ-042 Defaults: expect exactly 4 clocks from each adc_ch change to adc_soc, and smp_en exactly 1 clock after adc_eoc.
REQ-043 Inject adc_eoc during SETTLE: expect overrun=1, no smp_en; then clr_flags=1 -> overrun=0 next clock.
REQ-044 With the macro defined and TIMEOUT_CYC=16, withhold eoc on Q: expect timeout=1 17 clocks after soc, no Q emit, and the next emit is I.
REQ-045 Drop run during the Q conversion: expect the Q emit with pair_done, then IDLE with adc_ch=6 and no further adc_soc.
REQ-046 Assert rst in WAIT with eoc on the same clock: expect no smp_en, all outputs at their reset values, IDLE.
